// File: rtl/serial_slave_port.sv
// serial_slave_port: bit-serial bus slave with local word memory and bursts.
// Define SERIAL_SLAVE_SPLIT_EN to add a SPLIT_CYC-cycle split hold-off per read word.
module serial_slave_port #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int SPLIT_CYC = 8
) (
  input  logic S_CLK,
  input  logic S_RST,
  input  logic S_M_VALID,
  input  logic S_M_READY,
  input  logic S_RX_ADDR,
  input  logic S_RX_DATA,
  input  logic S_WRITE_EN,
  input  logic S_READ_EN,
  input  logic S_RX_BURST,
  output logic S_DATA_TX,
  output logic S_SLAVE_READY,
  output logic S_SLAVE_VALID,
  output logic S_SPLIT_EN,
  output logic S_TX_DONE
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam int WC_W  = $clog2(BURST_LEN) + 1;

  if (BURST_LEN < 2 || SPLIT_CYC < 1) begin : g_bad_param
    $error("serial_slave_port: BURST_LEN must be >= 2, SPLIT_CYC >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RLOAD,
`ifdef SERIAL_SLAVE_SPLIT_EN
    SPLIT,
`endif
    RDATA,
    DONE
  } state_t;

  state_t state, next;

  logic              is_wr;
  logic              burst;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic [WC_W-1:0]   left;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] mem [2**ADDR_W];

`ifdef SERIAL_SLAVE_SPLIT_EN
  localparam int SPW = $clog2(SPLIT_CYC) + 1;
  logic [SPW-1:0] split_cnt;
`endif

  logic              start;
  logic              addr_last;
  logic              data_last;
  logic              more;
  logic              wr_fire;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wr_word;

  assign start     = S_M_VALID && (S_WRITE_EN ^ S_READ_EN);
  assign addr_last = cnt == CNT_W'(ADDR_W - 1);
  assign data_last = cnt == CNT_W'(DATA_W - 1);
  assign more      = burst && (left > WC_W'(1));
  // LSB-first: new bit enters at the top, so the first bit ends at [0]
  assign addr_in   = (addr >> 1) | (ADDR_W'(S_RX_ADDR) << (ADDR_W - 1));
  assign wr_word   = (shift >> 1) | (DATA_W'(S_RX_DATA) << (DATA_W - 1));
  assign wr_fire   = (state == WDATA) && S_M_VALID && data_last && !S_RST;

  always_ff @(posedge S_CLK) begin
    if (S_RST) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next          = state;
    S_SLAVE_READY = 1'b0;
    S_SLAVE_VALID = 1'b0;
    S_DATA_TX     = 1'b0;
    S_SPLIT_EN    = 1'b0;
    S_TX_DONE     = 1'b0;
    unique case (state)
      IDLE: begin
        S_SLAVE_READY = 1'b1;
        if (start) begin
          if (ADDR_W == 1) next = S_WRITE_EN ? WDATA : RLOAD;
          else             next = ADDR;
        end
      end
      ADDR: begin
        S_SLAVE_READY = 1'b1;
        if (S_M_VALID && addr_last) next = is_wr ? WDATA : RLOAD;
      end
      WDATA: begin
        S_SLAVE_READY = 1'b1;
        if (S_M_VALID && data_last && !more) next = DONE;
      end
`ifdef SERIAL_SLAVE_SPLIT_EN
      RLOAD: next = SPLIT;
      SPLIT: begin
        S_SPLIT_EN = 1'b1;
        if (split_cnt == SPW'(SPLIT_CYC - 1)) next = RDATA;
      end
`else
      RLOAD: next = RDATA;
`endif
      RDATA: begin
        S_SLAVE_VALID = 1'b1;
        S_DATA_TX     = shift[0];
        if (S_M_READY && data_last) next = more ? RLOAD : DONE;
      end
      DONE: begin
        S_TX_DONE = 1'b1;
        next      = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge S_CLK) begin
    if (S_RST) begin
      is_wr <= 1'b0;
      burst <= 1'b0;
      addr  <= '0;
      cnt   <= '0;
      left  <= '0;
      shift <= '0;
`ifdef SERIAL_SLAVE_SPLIT_EN
      split_cnt <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (start) begin
          is_wr <= S_WRITE_EN;
          burst <= S_RX_BURST;
          addr  <= addr_in;
          cnt   <= (ADDR_W == 1) ? '0 : CNT_W'(1);
          left  <= S_RX_BURST ? WC_W'(BURST_LEN) : WC_W'(1);
        end
        ADDR: if (S_M_VALID) begin
          addr <= addr_in;
          cnt  <= addr_last ? '0 : cnt + 1'b1;
        end
        WDATA: if (S_M_VALID) begin
          shift <= wr_word;
          cnt   <= data_last ? '0 : cnt + 1'b1;
          if (data_last && more) begin
            addr <= addr + 1'b1;
            left <= left - 1'b1;
          end
        end
        RLOAD: begin
          shift <= mem[addr];
          cnt   <= '0;
`ifdef SERIAL_SLAVE_SPLIT_EN
          split_cnt <= '0;
`endif
        end
`ifdef SERIAL_SLAVE_SPLIT_EN
        SPLIT: split_cnt <= split_cnt + 1'b1;
`endif
        RDATA: if (S_M_READY) begin
          shift <= shift >> 1;
          cnt   <= data_last ? '0 : cnt + 1'b1;
          if (data_last && more) begin
            addr <= addr + 1'b1;
            left <= left - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset; completed words survive S_RST
  always_ff @(posedge S_CLK) begin
    if (wr_fire) mem[addr] <= wr_word;
  end

endmodule
